shake_squeeze_serializer: RTL and testbench

SHAKE_SQUEEZE_SERIALIZER -- requirements
Module: shake_squeeze_serializer

---
 rtl/shake_pkg.sv | 6 +
 rtl/shake_tail_mask.sv | 18 +
 rtl/shake_squeeze_serializer.sv | 118 +++++++++++
 tb/tb_shake_squeeze_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// shake_pkg: shared FSM encoding and word geometry for the SHAKE squeeze serializer.
package shake_pkg;
    localparam int WORD_BITS      = 64;
    localparam int BYTES_PER_WORD = 8;
    typedef enum logic [1:0] {IDLE, WAIT_BLK, STREAM} state_e;
endpackage

// File: rtl/shake_tail_mask.sv
// shake_tail_mask: maps remaining byte count to a 64-bit data mask and byte keep (bit 7 = byte 0).
module shake_tail_mask
    import shake_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [LEN_W-1:0] remaining,
    output logic [63:0]      mask,
    output logic [7:0]       keep
);
    logic [3:0] n;
    always_comb begin
        n    = (remaining >= LEN_W'(BYTES_PER_WORD)) ? 4'd8 : remaining[3:0];
        keep = 8'hFF << (4'd8 - n);
        mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) mask[63-8*i -: 8] = {8{keep[7-i]}};
    end
endmodule

// File: rtl/shake_squeeze_serializer.sv
// shake_squeeze_serializer: turns OUT_BITS squeezed blocks into a length-limited 64-bit word stream.
// Optional SHAKE_SER_KEEP_EN adds an m_keep byte-enable output.
module shake_squeeze_serializer
    import shake_pkg::*;
#(
    parameter int OUT_BITS = 512,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    out_len_bytes,
    input  logic                blk_valid,
    input  logic [OUT_BITS-1:0] blk_data,
    output logic                blk_ready,
    output logic                squeeze_req,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [63:0]         m_data,
    output logic                m_last,
    output logic                busy,
`ifdef SHAKE_SER_KEEP_EN
    output logic [7:0]          m_keep,
`endif
    output logic                done
);
    localparam int WORDS = OUT_BITS / WORD_BITS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [OUT_BITS-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sq_q, sq_d, done_q, done_d;
    logic                last;
    logic [LEN_W-1:0]    step;
    logic [63:0]         tail_mask;
    logic [7:0]          tail_keep;

    assign last = rem_q <= LEN_W'(BYTES_PER_WORD);
    assign step = last ? rem_q : LEN_W'(BYTES_PER_WORD);

    shake_tail_mask #(.LEN_W(LEN_W)) u_mask (
        .remaining(rem_q),
        .mask     (tail_mask),
        .keep     (tail_keep)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        sq_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (out_len_bytes == '0) done_d = 1'b1;
                else begin
                    rem_d   = out_len_bytes;
                    state_d = WAIT_BLK;
                    sq_d    = 1'b1;
                end
            end
            WAIT_BLK: if (blk_valid) begin
                buf_d   = blk_data;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: if (m_ready) begin
                rem_d = rem_q - step;
                buf_d = buf_q << WORD_BITS;
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (idx_q == IDX_W'(WORDS - 1)) begin
                    state_d = WAIT_BLK;
                    sq_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            sq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            sq_q    <= sq_d;
            done_q  <= done_d;
        end
    end

    // All outputs decode from registered state so reset clears them immediately.
    assign m_valid     = state_q == STREAM;
    assign blk_ready   = state_q == WAIT_BLK;
    assign m_last      = m_valid && last;
    assign busy        = state_q != IDLE;
    assign squeeze_req = sq_q;
    assign done        = done_q;
    assign m_data      = m_valid ? (buf_q[OUT_BITS-1 -: WORD_BITS] & tail_mask) : 64'h0;
`ifdef SHAKE_SER_KEEP_EN
    assign m_keep      = m_valid ? tail_keep : 8'h00;
`else
    logic [7:0] unused_keep;
    assign unused_keep = tail_keep;
`endif
endmodule

// File: tb/tb_shake_squeeze_serializer.sv
// tb_shake_squeeze_serializer: table-driven jobs against a byte-stream reference model.
module tb_shake_squeeze_serializer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  out_len_bytes = '0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready, squeeze_req, m_valid, m_last, busy, done;
    logic         m_ready = 1'b0;
    logic [63:0]  m_data;
`ifdef SHAKE_SER_KEEP_EN
    logic [7:0]   m_keep;
`endif
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shake_squeeze_serializer #(.OUT_BITS(512), .LEN_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .out_len_bytes(out_len_bytes),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
        .squeeze_req(squeeze_req), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy),
`ifdef SHAKE_SER_KEEP_EN
        .m_keep(m_keep),
`endif
        .done(done)
    );

    typedef struct {
        int         len;
        bit         stall;
        bit         poke;
        int         abort_w;
        int         words;
        int         sq;
        logic [7:0] keep_last;
    } vec_t;

    function automatic logic [7:0] blk_byte(int k, int i);
        return 8'(k * 83 + i * 29 + 17);
    endfunction

    function automatic logic [511:0] mk_blk(int k);
        logic [511:0] b = '0;
        for (int i = 0; i < 64; i++) b[511-8*i -: 8] = blk_byte(k, i);
        return b;
    endfunction

    function automatic logic [63:0] exp_word(int len, int j);
        logic [63:0] w = '0;
        for (int b = 0; b < 8; b++)
            if (8 * j + b < len) w[63-8*b -: 8] = blk_byte((8 * j + b) / 64, (8 * j + b) % 64);
        return w;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(string name);
        chk({name, " m_valid"}, 64'(m_valid), 64'h0);
        chk({name, " blk_ready"}, 64'(blk_ready), 64'h0);
        chk({name, " squeeze_req"}, 64'(squeeze_req), 64'h0);
        chk({name, " m_last"}, 64'(m_last), 64'h0);
        chk({name, " busy"}, 64'(busy), 64'h0);
        chk({name, " done"}, 64'(done), 64'h0);
        chk({name, " m_data"}, m_data, 64'h0);
`ifdef SHAKE_SER_KEEP_EN
        chk({name, " m_keep"}, 64'(m_keep), 64'h0);
`endif
    endtask

    task automatic run_job(vec_t v);
        int w = 0, sq = 0, bc = 0;
        bit want = 0, fin = 0, prev_stall = 0;
        logic [63:0] prev_data = '0;
        logic prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_len_bytes = 16'(v.len);
        m_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            if (done) begin
                fin = 1;
                break;
            end
            if (squeeze_req) begin
                sq++;
                want = 1;
            end
            blk_valid = want;
            blk_data = mk_blk(bc);
            if (blk_valid && blk_ready) begin
                bc++;
                want = 0;
            end
            if (m_valid && prev_stall) begin
                chk("stall m_data", m_data, prev_data);
                chk("stall m_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && v.abort_w == w) begin
                #2 reset_n = 1'b0;
                #1 chk_all_zero("async reset");
                blk_valid = 1'b0;
                m_ready = 1'b0;
                @(negedge clk);
                chk_all_zero("held reset");
                reset_n = 1'b1;
                return;
            end
            if (m_valid && w >= v.words) begin
                chk("unexpected word", 64'(w), 64'(v.words));
                fin = 1;
                break;
            end
            m_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (v.poke && m_valid && w == 2) begin
                start = 1'b1;
                out_len_bytes = 16'd5;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (m_valid && m_ready) begin
                chk($sformatf("len%0d word%0d data", v.len, w), m_data, exp_word(v.len, w));
                chk($sformatf("len%0d word%0d last", v.len, w), 64'(m_last), 64'(w == v.words - 1));
`ifdef SHAKE_SER_KEEP_EN
                chk($sformatf("len%0d word%0d keep", v.len, w), 64'(m_keep),
                    64'((w == v.words - 1) ? v.keep_last : 8'hFF));
`endif
                w++;
            end
        end
        if (!fin) chk($sformatf("len%0d done timeout", v.len), 64'(fin), 64'h1);
        blk_valid = 1'b0;
        m_ready = 1'b0;
        chk($sformatf("len%0d word count", v.len), 64'(w), 64'(v.words));
        chk($sformatf("len%0d squeeze_req count", v.len), 64'(sq), 64'(v.sq));
        @(negedge clk);
        chk($sformatf("len%0d done one cycle", v.len), 64'(done), 64'h0);
        chk($sformatf("len%0d idle busy", v.len), 64'(busy), 64'h0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{len: 32,  stall: 0, poke: 0, abort_w: -1, words: 4,  sq: 1, keep_last: 8'hFF};
        tbl[1] = '{len: 64,  stall: 0, poke: 0, abort_w: -1, words: 8,  sq: 1, keep_last: 8'hFF};
        tbl[2] = '{len: 70,  stall: 0, poke: 0, abort_w: -1, words: 9,  sq: 2, keep_last: 8'hFC};
        tbl[3] = '{len: 70,  stall: 1, poke: 1, abort_w: -1, words: 9,  sq: 2, keep_last: 8'hFC};
        tbl[4] = '{len: 0,   stall: 0, poke: 0, abort_w: -1, words: 0,  sq: 0, keep_last: 8'h00};
        tbl[5] = '{len: 64,  stall: 0, poke: 0, abort_w: 2,  words: 8,  sq: 1, keep_last: 8'hFF};
        tbl[6] = '{len: 8,   stall: 0, poke: 0, abort_w: -1, words: 1,  sq: 1, keep_last: 8'hFF};
        tbl[7] = '{len: 3,   stall: 1, poke: 0, abort_w: -1, words: 1,  sq: 1, keep_last: 8'hE0};
        tbl[8] = '{len: 130, stall: 1, poke: 0, abort_w: -1, words: 17, sq: 3, keep_last: 8'hC0};
        tbl[9] = '{len: 127, stall: 0, poke: 0, abort_w: -1, words: 16, sq: 2, keep_last: 8'hFE};
        repeat (3) @(negedge clk);
        chk_all_zero("power-on reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) run_job(tbl[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
